// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_pkg
//  Purpose  : Shared header for the serial example designs. Holds the common
//             FSM state encodings used by the bit-serial datapaths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    localparam int unsigned c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_STATE_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_STATE_RUN  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_STATE_DONE = 2'd2;

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_half_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : half_subtractor
//  Purpose  : One-bit half subtractor. Two of these plus an OR gate form the
//             per-bit full subtractor of serial_subtractor.
//  Ports    : Input_A    in  1  minuend bit
//             Input_B    in  1  subtrahend bit
//             Difference out 1  Input_A ^ Input_B
//             Borrow     out 1  ~Input_A & Input_B
//  Revision : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  logic Input_A,
    input  logic Input_B,
    output logic Difference,
    output logic Borrow
);

    assign Difference = Input_A ^ Input_B;
    assign Borrow     = ~Input_A & Input_B;

endmodule : half_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial unsigned subtractor. Accepts A and B over a
//             valid/ready handshake, computes A-B LSB-first one bit per clock
//             and returns the difference and final borrow over a second
//             valid/ready handshake.
//  Ports    : Clock       in  1      design clock, rising edge
//             Reset       in  1      asynchronous, active-high reset
//             In_Valid    in  1      operands present
//             In_Ready    out 1      block can accept operands
//             Operand_A   in  WIDTH  minuend, unsigned
//             Operand_B   in  WIDTH  subtrahend, unsigned
//             Out_Valid   out 1      result present
//             Out_Ready   in  1      consumer takes result
//             Difference  out WIDTH  (A-B) mod 2^WIDTH, 0 when Out_Valid=0
//             Borrow      out 1      1 iff A < B, 0 when Out_Valid=0
//             Busy        out 1      operation in progress
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Difference,
    output logic             Borrow,
    output logic             Busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // RUN leaves once the counter has reached WIDTH; the cycle that sees the
    // full count does no arithmetic, giving the WIDTH+1 cycle accept-to-valid
    // latency.
    localparam logic [CNT_W-1:0] c_COUNT_FULL = CNT_W'(WIDTH);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_result;
    logic                 r_borrow;
    logic [CNT_W-1:0]     r_count;

    logic                 w_accept;
    logic                 w_step;
    logic                 w_hs0_diff;
    logic                 w_hs0_borrow;
    logic                 w_bit_diff;
    logic                 w_hs1_borrow;
    logic                 w_bit_borrow;
    logic [WIDTH:0]       w_result_shift;

    assign w_accept = (r_state == c_STATE_IDLE) && In_Valid;
    assign w_step   = (r_state == c_STATE_RUN) && (r_count != c_COUNT_FULL);

    // ------------------------------------------------------------------
    // Per-bit full subtractor: a0 - b0 - borrow_in
    // ------------------------------------------------------------------
    half_subtractor u_hs_ab (
        .Input_A    (r_a[0]),
        .Input_B    (r_b[0]),
        .Difference (w_hs0_diff),
        .Borrow     (w_hs0_borrow)
    );

    half_subtractor u_hs_bor (
        .Input_A    (w_hs0_diff),
        .Input_B    (r_borrow),
        .Difference (w_bit_diff),
        .Borrow     (w_hs1_borrow)
    );

    assign w_bit_borrow = w_hs0_borrow | w_hs1_borrow;

    // New bit enters at the MSB; written as a wide shift so WIDTH=1 works.
    assign w_result_shift = {w_bit_diff, r_result};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= c_STATE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_STATE_IDLE: if (In_Valid)                 w_next_state = c_STATE_RUN;
            c_STATE_RUN:  if (r_count == c_COUNT_FULL)  w_next_state = c_STATE_DONE;
            c_STATE_DONE: if (Out_Ready)                w_next_state = c_STATE_IDLE;
            default:                                    w_next_state = c_STATE_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (result is masked whenever it is not being offered)
    // ------------------------------------------------------------------
    always_comb begin
        In_Ready   = (r_state == c_STATE_IDLE);
        Out_Valid  = (r_state == c_STATE_DONE);
        Busy       = (r_state != c_STATE_IDLE);
        Difference = '0;
        Borrow     = 1'b0;
        if (r_state == c_STATE_DONE) begin
            Difference = r_result;
            Borrow     = r_borrow;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand/result shift registers, borrow flop, bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_a      <= Operand_A;
            r_b      <= Operand_B;
            r_result <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else if (w_step) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_result <= w_result_shift[WIDTH:1];
            r_borrow <= w_bit_borrow;
            r_count  <= r_count + CNT_W'(1);
        end
    end

endmodule : serial_subtractor
`default_nettype wire
